// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver with a shared segment
// bus and per-digit anode enables. New values wait in a pending register and
// are moved to the display register only on the frame wrap, so a frame never
// mixes old and new digits.
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic                  wrap_q;

    logic [4*DIGITS-1:0]   pend_value;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_lz;
    logic                  pend_valid;
    logic [4*DIGITS-1:0]   disp_value;
    logic [DIGITS-1:0]     disp_dp;
    logic                  disp_lz;

    logic [3:0]            nib;
    logic [6:0]            seg_dec;
    logic [DIGITS-1:0]     blank_vec;
    logic                  zero_run;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [DIGITS-1:0]     an_n;

    // Slot tick and frame wrap derived from the scan position.
    always_comb begin
        tick = enable && (cnt == PS_LAST);
        wrap = tick && (idx == IDX_LAST);
    end

    // Prescaler and digit index; both freeze while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending capture and tear-free transfer to the display register on wrap.
    // A load coinciding with the wrap bypasses pending entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_lz    <= 1'b0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_lz    <= lz_blank;
            end
            if (wrap && load) begin
                disp_value <= value;
                disp_dp    <= dp_in;
                disp_lz    <= lz_blank;
                pend_valid <= 1'b0;
            end else if (wrap && pend_valid) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_lz    <= pend_lz;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Leading-zero map: digit k>0 blanks when it and every higher nibble are zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (disp_value[4*k +: 4] == 4'h0);
            blank_vec[k] = zero_run;
        end
    end

    // Hex decode of the active digit, active-high {a,b,c,d,e,f,g}.
    always_comb begin
        nib = disp_value[4*int'(idx) +: 4];
        case (nib)
            4'h0: seg_dec = 7'b1111110;
            4'h1: seg_dec = 7'b0110000;
            4'h2: seg_dec = 7'b1101101;
            4'h3: seg_dec = 7'b1111001;
            4'h4: seg_dec = 7'b0110011;
            4'h5: seg_dec = 7'b1011011;
            4'h6: seg_dec = 7'b1011111;
            4'h7: seg_dec = 7'b1110000;
            4'h8: seg_dec = 7'b1111111;
            4'h9: seg_dec = 7'b1111011;
            4'hA: seg_dec = 7'b1110111;
            4'hB: seg_dec = 7'b0011111;
            4'hC: seg_dec = 7'b1001110;
            4'hD: seg_dec = 7'b0111101;
            4'hE: seg_dec = 7'b1001111;
            default: seg_dec = 7'b1000111;
        endcase
    end

    // Next output values before polarity; everything dark while disabled.
    always_comb begin
        seg_n = '0;
        dp_n  = 1'b0;
        an_n  = '0;
        if (enable) begin
            seg_n = (disp_lz && blank_vec[idx]) ? 7'b0000000 : seg_dec;
            dp_n  = disp_dp[idx];
            an_n  = DIGITS'(1) << idx;
        end
    end

    // Registered outputs with polarity applied; frame_done lines up with the
    // first digit-0 output of the newly transferred frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
            an         <= {DIGITS{AN_ACTIVE_LOW}};
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_n ^ {7{SEG_ACTIVE_LOW}};
            dp         <= dp_n ^ SEG_ACTIVE_LOW;
            an         <= an_n ^ {DIGITS{AN_ACTIVE_LOW}};
            wrap_q     <= wrap;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, PRESCALE=4). The stimulus script pushes
// the expected contents of each digit slot; the monitor pops one entry each
// time a new digit becomes active and checks segments, dp, anodes,
// frame_done, slot length and in-slot stability.
module tb_seg_scan_driver;

    localparam int D = 4;
    localparam int P = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [3:0] len;
    } slot_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          lz_blank;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    slot_t exp_q[$];
    slot_t cur;
    logic [3:0] prev_an = 4'hF;
    int run_len = 0;
    logic mon_on = 1'b1;

    seg_scan_driver #(
        .DIGITS(D), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_slot(input int k, input logic [6:0] s, input logic d,
                             input logic fd, input logic [3:0] len);
        slot_t e;
        e.an  = ~(4'b0001 << k);
        e.seg = s;
        e.dp  = d;
        e.fd  = fd;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm,
                              input logic [3:0] blank, input logic fd,
                              input logic [3:0] last_len);
        for (int k = 0; k < D; k++)
            push_slot(k, blank[k] ? 7'b0000000 : SEG_TAB[v[4*k +: 4]], dpm[k],
                      fd && (k == 0), (k == D - 1) ? last_len : 4'd4);
    endtask

    task automatic check_dark(input string name);
        check({name, "_an"}, 32'(an), 32'hF);
        check({name, "_seg"}, 32'(seg), 32'h0);
        check({name, "_dp"}, 32'(dp), 32'h0);
    endtask

    // Monitor: a change of active anode starts a new slot and pops one entry.
    always @(negedge clk) begin
        if (mon_on) begin
            logic popped;
            popped = 1'b0;
            if (an != prev_an) begin
                if (prev_an != 4'hF && cur.len != 4'd0)
                    check("slot_len", 32'(run_len), 32'(cur.len));
                if (an != 4'hF) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_slot: an=%b with empty queue at %0t", an, $time);
                    end else begin
                        cur = exp_q.pop_front();
                        popped = 1'b1;
                        check("slot_an", 32'(an), 32'(cur.an));
                        check("slot_seg", 32'(seg), 32'(cur.seg));
                        check("slot_dp", 32'(dp), 32'(cur.dp));
                    end
                    run_len = 1;
                end
            end else if (an != 4'hF) begin
                run_len++;
                check("hold_seg", 32'(seg), 32'(cur.seg));
                check("hold_dp", 32'(dp), 32'(cur.dp));
            end
            check("frame_done", 32'(frame_done), 32'(popped && cur.fd));
            prev_an = an;
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_dark("reset");
        end
        // Now at the negedge of cycle 0; the next edge samples rst low.
        for (int c = 0; c <= 214; c++) begin
            load = 1'b0;
            case (c)
                0:   begin rst = 1'b0; push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd4); end
                2:   begin load = 1'b1; value = 16'h3210; dp_in = 4'b0000; lz_blank = 1'b0; end
                16:  push_frame(16'h3210, 4'b0000, 4'b0000, 1'b1, 4'd4);
                18:  begin load = 1'b1; value = 16'h7654; end
                32:  push_frame(16'h7654, 4'b0000, 4'b0000, 1'b1, 4'd4);
                34:  begin load = 1'b1; value = 16'hBA98; end
                48:  push_frame(16'hBA98, 4'b0000, 4'b0000, 1'b1, 4'd4);
                50:  begin load = 1'b1; value = 16'hFEDC; end
                64:  push_frame(16'hFEDC, 4'b0000, 4'b0000, 1'b1, 4'd4);
                66:  begin load = 1'b1; value = 16'h0050; lz_blank = 1'b1; end
                80:  push_frame(16'h0050, 4'b0000, 4'b1100, 1'b1, 4'd4);
                82:  begin load = 1'b1; value = 16'h0000; lz_blank = 1'b1; end
                96:  push_frame(16'h0000, 4'b0000, 4'b1110, 1'b1, 4'd4);
                98:  begin load = 1'b1; value = 16'h1111; lz_blank = 1'b0; end
                100: begin load = 1'b1; value = 16'h2222; end
                112: push_frame(16'h2222, 4'b0000, 4'b0000, 1'b1, 4'd4);
                127: begin load = 1'b1; value = 16'h3333; end
                128: push_frame(16'h3333, 4'b0000, 4'b0000, 1'b1, 4'd4);
                130: begin load = 1'b1; value = 16'h3333; dp_in = 4'b0100; end
                144: begin
                    push_slot(0, SEG_TAB[3], 1'b0, 1'b1, 4'd4);
                    push_slot(1, SEG_TAB[3], 1'b0, 1'b0, 4'd1);
                    push_slot(1, SEG_TAB[3], 1'b0, 1'b0, 4'd3);
                    push_slot(2, SEG_TAB[3], 1'b1, 1'b0, 4'd4);
                    push_slot(3, SEG_TAB[3], 1'b0, 1'b0, 4'd4);
                end
                149: enable = 1'b0;
                155: enable = 1'b1;
                166: push_frame(16'h3333, 4'b0100, 4'b0000, 1'b1, 4'd0);
                181: begin rst = 1'b1; load = 1'b1; value = 16'h9999; dp_in = 4'b1111; end
                182: begin
                    check_dark("midreset");
                    check("midreset_fd", 32'(frame_done), 32'h0);
                    rst = 1'b0;
                    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd4);
                end
                198: push_frame(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'd0);
                default: ;
            endcase
            if (c >= 150 && c <= 155) check_dark("disabled");
            @(negedge clk);
        end
        mon_on = 1'b0;
        check("queue_left", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
